pipelinediv_hs: RTL and testbench
=================================

PIPELINEDIV_HS -- requirements
Module: pipelinediv_hs

Interface
REQ-001 SHALL have parameter DIVIDENDLEN, default 16, dividend and quotient width (>=4).
REQ-002 SHALL have parameter DIVISORLEN, default 8, divisor and remainder width (>=2, <=DIVIDENDLEN).
REQ-003 SHALL have parameter TAGLEN, default 4, width of the sideband tag carried with each operation (>=1).
REQ-004 SHALL have one clock and a synchronous, active-low reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset_n  input  1  synchronous reset, active low.
REQ-007 in_valid  input  1  operation presented.
REQ-008 in_ready  output  1  operation accepted when in_valid && in_ready at a rising edge.
REQ-009 in_signed  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-010 in_tag  input  TAGLEN  sideband tag, returned unchanged with the result.
REQ-011 dividend  input  DIVIDENDLEN  numerator.
REQ-012 divisor  input  DIVISORLEN  denominator.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  result consumed when out_valid && out_ready at a rising edge.
REQ-015 quotient  output  DIVIDENDLEN  quotient.
REQ-016 remainder  output  DIVISORLEN  remainder.
REQ-017 out_div_by_zero  output  1  divisor was zero.
REQ-018 out_tag  output  TAGLEN  tag of the operation.
REQ-019 busy  output  1  any pipeline stage holds a valid operation.

Function
REQ-020 SHALL be organised as L = DIVIDENDLEN+2 register stages: an input stage, DIVIDENDLEN restoring-division stages, and an output fix-up stage.
REQ-021 Input stage SHALL register operand magnitudes (absolute values when in_signed=1), the quotient sign (sign(dividend) XOR sign(divisor)), the remainder sign (sign(dividend)), the zero-divisor flag, in_signed and in_tag.
REQ-022 Division stage k (k=0..DIVIDENDLEN-1) SHALL resolve quotient bit DIVIDENDLEN-1-k: subtract the divisor shifted left by DIVIDENDLEN-1-k from the partial remainder, set the bit to 1 and keep the difference if non-negative, else set 0 and keep the partial remainder.
REQ-023 The datapath SHALL be DIVIDENDLEN+DIVISORLEN-1 bits with no overflow.
REQ-024 Output stage SHALL negate the quotient if its sign is 1, negate the remainder if its sign is 1, and register the result.
REQ-025 Unsigned results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.
REQ-026 Signed results SHALL truncate toward zero; the remainder takes the dividend's sign.
REQ-027 Signed most-negative dividend / -1 SHALL give quotient = most-negative and remainder = 0, with no flag.
REQ-028 A divisor of 0 SHALL give quotient = all ones, remainder = dividend[DIVISORLEN-1:0] and out_div_by_zero = 1, in both modes, with the same latency as any other operation.
REQ-029 All stages SHALL share one advance enable, adv = !out_valid || out_ready; when adv=0 every stage holds.
REQ-030 in_ready SHALL equal adv, combinationally.
REQ-031 On adv=1, a cycle with no input handshake SHALL insert a bubble (valid=0) into the input stage.
REQ-032 Throughput SHALL be one operation per clock with no stall.
REQ-033 An operation accepted at edge n SHALL appear with out_valid=1 after edge n+L-1 if adv stays 1.
REQ-034 Results SHALL leave in acceptance order.
REQ-035 Simultaneous output consume and input accept in one cycle SHALL both take effect.
REQ-036 quotient, remainder, out_div_by_zero and out_tag SHALL hold stable while out_valid=1 && out_ready=0.

Reset
REQ-037 While reset_n=0 at an edge, all stage valid bits SHALL clear; out_valid=0 and busy=0 from the following cycle.
REQ-038 Reset SHALL set quotient, remainder, out_tag and out_div_by_zero to 0.
REQ-039 Reset mid-operation SHALL discard all in-flight operations; none SHALL emerge afterwards.
REQ-040 in_ready SHALL be 1 in the first cycle after reset.
REQ-041 A handshake in a reset cycle SHALL be ignored.

Structure
REQ-042 Package pipediv_pkg SHALL hold a parameterisable stage struct (valid, partial remainder, divisor magnitude, quotient, quotient sign, remainder sign, dbz, signed, tag) and functions for width calculation.
REQ-043 One sub-module, divstage, SHALL implement the combinational step of REQ-022, parametrised by bit position; it is instantiated DIVIDENDLEN times in a generate loop.
REQ-044 All registers SHALL live in pipelinediv_hs.

Verification (DIVIDENDLEN=16, DIVISORLEN=8, TAGLEN=4)
REQ-045 Unsigned 1000/7, tag 3 -> after 18 cycles: quotient 142, remainder 6, tag 3, flag 0.
REQ-046 Signed 0xFF9C(-100)/0x07 -> quotient 0xFFF2(-14), remainder 0xFE(-2); signed 0x8000/0xFF -> quotient 0x8000, remainder 0x00, flag 0.
REQ-047 0x1234/0 in both modes -> quotient 0xFFFF, remainder 0x34, flag 1, latency 18.
REQ-048 20 random operations back to back with out_ready=1 -> 20 consecutive out_valid cycles, in order, all matching a reference model.
REQ-049 out_ready held low for 5 cycles while out_valid=1 -> outputs stable, in_ready=0; after release, no operation lost or duplicated.
REQ-050 reset_n pulsed low with 10 operations in flight -> out_valid=0 and busy=0 next cycle; no stale results afterwards.

Source files
------------

// File: rtl/pipediv_pkg.sv
// Shared types and width helpers for the pipelined restoring divider.
package pipediv_pkg;

    // Per-stage control flags. Packages cannot take parameters, so the
    // width-dependent fields are added around this struct in the top module.
    typedef struct packed {
        logic valid;  // stage holds an operation
        logic q_neg;  // quotient must be negated at the output
        logic r_neg;  // remainder must be negated at the output
        logic dbz;    // divisor was zero
        logic sgn;    // operation was signed
    } stage_ctl_t;

    // Partial remainder width: divisor shifted by up to DIVIDENDLEN-1 bits.
    function automatic int rem_w(input int dl, input int dvl);
        return dl + dvl - 1;
    endfunction

    // Trial-subtraction width: one extra bit to catch the borrow.
    function automatic int diff_w(input int dl, input int dvl);
        return rem_w(dl, dvl) + 1;
    endfunction

endpackage

// File: rtl/divstage.sv
// One restoring-division step: resolves the quotient bit at BITPOS.
module divstage
    import pipediv_pkg::*;
#(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8,
    parameter int BITPOS      = 0
) (
    input  logic [rem_w(DIVIDENDLEN, DIVISORLEN)-1:0] rem_in,
    input  logic [DIVISORLEN-1:0]                     dvs,
    output logic [rem_w(DIVIDENDLEN, DIVISORLEN)-1:0] rem_out,
    output logic                                      qbit
);
    localparam int RW = rem_w(DIVIDENDLEN, DIVISORLEN);

    logic [RW-1:0]                                 shifted;
    logic [diff_w(DIVIDENDLEN, DIVISORLEN)-1:0]    diff;

    // Trial subtract; keep the difference only when it did not borrow.
    always_comb begin
        shifted = {{(DIVIDENDLEN-1){1'b0}}, dvs} << BITPOS;
        diff    = {1'b0, rem_in} - {1'b0, shifted};
        qbit    = ~diff[RW];
        rem_out = qbit ? diff[RW-1:0] : rem_in;
    end

endmodule

// File: rtl/pipelinediv_hs.sv
// Fully pipelined signed/unsigned divider with valid/ready handshake.
// Stage 0 registers magnitudes, stages 1..DIVIDENDLEN each resolve one
// quotient bit, and the output registers apply the sign fix-up.
module pipelinediv_hs
    import pipediv_pkg::*;
#(
    parameter int DIVIDENDLEN = 16,
    parameter int DIVISORLEN  = 8,
    parameter int TAGLEN      = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_signed,
    input  logic [TAGLEN-1:0]      in_tag,
    input  logic [DIVIDENDLEN-1:0] dividend,
    input  logic [DIVISORLEN-1:0]  divisor,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DIVIDENDLEN-1:0] quotient,
    output logic [DIVISORLEN-1:0]  remainder,
    output logic                   out_div_by_zero,
    output logic [TAGLEN-1:0]      out_tag,
    output logic                   busy
);
    localparam int DL  = DIVIDENDLEN;
    localparam int DVL = DIVISORLEN;
    localparam int RW  = rem_w(DL, DVL);

    typedef struct packed {
        stage_ctl_t        ctl;
        logic [RW-1:0]     rem;
        logic [DVL-1:0]    dvs;
        logic [DL-1:0]     quo;
        logic [TAGLEN-1:0] tag;
    } stage_t;

    // pipe[0] is the input stage, pipe[k+1] holds the result of division step k.
    stage_t                  pipe [DL+1];
    stage_t                  in_stage;
    logic                    adv;
    logic [DL-1:0][RW-1:0]   rem_nxt;
    logic [DL-1:0]           qbit;
    logic                    dvd_neg;
    logic                    dvs_neg;
    logic [DL-1:0]           dvd_mag;
    logic [DVL-1:0]          dvs_mag;
    logic [DL-1:0]           q_fix;
    logic [DVL-1:0]          r_fix;
    logic                    unused_tail;

    // Single advance enable: the whole pipe moves only if the output can.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Input conditioning: magnitudes and result signs.
    always_comb begin
        in_stage = '0;
        dvd_neg  = in_signed & dividend[DL-1];
        dvs_neg  = in_signed & divisor[DVL-1];
        dvd_mag  = dvd_neg ? -dividend : dividend;
        dvs_mag  = dvs_neg ? -divisor  : divisor;
        in_stage.ctl.valid = in_valid;
        in_stage.ctl.q_neg = dvd_neg ^ dvs_neg;
        in_stage.ctl.r_neg = dvd_neg;
        in_stage.ctl.dbz   = (divisor == '0);
        in_stage.ctl.sgn   = in_signed;
        in_stage.rem       = {{(DVL-1){1'b0}}, dvd_mag};
        in_stage.dvs       = dvs_mag;
        in_stage.tag       = in_tag;
    end

    for (genvar k = 0; k < DL; k++) begin : g_stage
        divstage #(
            .DIVIDENDLEN (DL),
            .DIVISORLEN  (DVL),
            .BITPOS      (DL-1-k)
        ) u_divstage (
            .rem_in  (pipe[k].rem),
            .dvs     (pipe[k].dvs),
            .rem_out (rem_nxt[k]),
            .qbit    (qbit[k])
        );
    end

    // Sign fix-up. A zero divisor forces all-ones; the remainder negation
    // then reproduces the raw dividend low bits in signed mode too.
    always_comb begin
        q_fix = pipe[DL].quo;
        if (pipe[DL].ctl.dbz)
            q_fix = '1;
        else if (pipe[DL].ctl.q_neg)
            q_fix = -pipe[DL].quo;
        r_fix = pipe[DL].rem[DVL-1:0];
        if (pipe[DL].ctl.r_neg)
            r_fix = -pipe[DL].rem[DVL-1:0];
    end

    // Fields of the last division stage that the output does not need.
    assign unused_tail = ^{pipe[DL].rem[RW-1:DVL], pipe[DL].dvs, pipe[DL].ctl.sgn};

    // Pipeline registers: all stages advance together or all hold.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i <= DL; i++)
                pipe[i] <= '0;
            out_valid       <= 1'b0;
            quotient        <= '0;
            remainder       <= '0;
            out_div_by_zero <= 1'b0;
            out_tag         <= '0;
        end else if (adv) begin
            pipe[0] <= in_stage;
            for (int k = 0; k < DL; k++) begin
                pipe[k+1]             <= pipe[k];
                pipe[k+1].rem         <= rem_nxt[k];
                pipe[k+1].quo[DL-1-k] <= qbit[k];
            end
            out_valid       <= pipe[DL].ctl.valid;
            quotient        <= q_fix;
            remainder       <= r_fix;
            out_div_by_zero <= pipe[DL].ctl.dbz;
            out_tag         <= pipe[DL].tag;
        end
    end

    // Busy whenever any stage, including the output register, is occupied.
    always_comb begin
        busy = out_valid;
        for (int i = 0; i <= DL; i++)
            busy = busy | pipe[i].ctl.valid;
    end

endmodule

// File: tb/tb_pipelinediv_hs.sv
// Directed and randomized checks for pipelinediv_hs (16/8/4 configuration).
module tb_pipelinediv_hs;
    localparam int DL  = 16;
    localparam int DVL = 8;
    localparam int TL  = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [TL-1:0]  in_tag;
    logic [DL-1:0]  dividend;
    logic [DVL-1:0] divisor;
    logic           out_valid;
    logic           out_ready;
    logic [DL-1:0]  quotient;
    logic [DVL-1:0] remainder;
    logic           out_div_by_zero;
    logic [TL-1:0]  out_tag;
    logic           busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic           sgn;
        logic [DL-1:0]  a;
        logic [DVL-1:0] b;
        logic [TL-1:0]  tag;
        logic [DL-1:0]  q;
        logic [DVL-1:0] r;
        logic           dbz;
    } op_t;

    op_t sb [$];

    always #5 clock = ~clock;

    pipelinediv_hs #(.DIVIDENDLEN(DL), .DIVISORLEN(DVL), .TAGLEN(TL)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_signed       (in_signed),
        .in_tag          (in_tag),
        .dividend        (dividend),
        .divisor         (divisor),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .quotient        (quotient),
        .remainder       (remainder),
        .out_div_by_zero (out_div_by_zero),
        .out_tag         (out_tag),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model built on native integer division.
    function automatic op_t mk(input logic sgn, input logic [DL-1:0] a,
                               input logic [DVL-1:0] b, input logic [TL-1:0] tag);
        op_t o;
        int  sa, sb_, qi, ri;
        o.sgn = sgn; o.a = a; o.b = b; o.tag = tag; o.dbz = 1'b0;
        if (b == '0) begin
            o.q = '1; o.r = a[DVL-1:0]; o.dbz = 1'b1;
        end else if (!sgn) begin
            o.q = a / b;
            qi  = int'(a % b);
            o.r = qi[DVL-1:0];
        end else begin
            sa  = int'($signed(a));
            sb_ = int'($signed(b));
            qi  = sa / sb_;
            ri  = sa % sb_;
            o.q = qi[DL-1:0];
            o.r = ri[DVL-1:0];
        end
        return o;
    endfunction

    task automatic check_out(input string name, input op_t o);
        chk({name, "_q"},   quotient,        o.q);
        chk({name, "_r"},   remainder,       o.r);
        chk({name, "_dbz"}, out_div_by_zero, o.dbz);
        chk({name, "_tag"}, out_tag,         o.tag);
    endtask

    // Single operation into an idle pipe; checks latency and the result.
    task automatic run_one(input string name, input logic sgn, input logic [DL-1:0] a,
                           input logic [DVL-1:0] b, input logic [TL-1:0] tag,
                           input logic [DL-1:0] eq, input logic [DVL-1:0] er, input logic edbz);
        int  lat;
        op_t o;
        @(negedge clock);
        in_valid = 1'b1; in_signed = sgn; dividend = a; divisor = b; in_tag = tag;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
        chk({name, "_lat"}, lat, 17);
        o.sgn = sgn; o.a = a; o.b = b; o.tag = tag; o.q = eq; o.r = er; o.dbz = edbz;
        check_out(name, o);
    endtask

    task automatic drive(input op_t o);
        @(negedge clock);
        in_valid = 1'b1; in_signed = o.sgn; dividend = o.a; divisor = o.b; in_tag = o.tag;
        sb.push_back(o);
        @(posedge clock);
    endtask

    function automatic op_t rand_op(input int i);
        logic           sgn;
        logic [DL-1:0]  a;
        logic [DVL-1:0] b;
        logic [TL-1:0]  t;
        sgn = 1'($urandom_range(0, 1));
        a   = DL'($urandom);
        b   = ($urandom_range(0, 7) == 0) ? '0 : DVL'($urandom);
        t   = i[TL-1:0];
        return mk(sgn, a, b, t);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt, idx, w;
        reset_n = 1'b0; in_valid = 1'b1; in_signed = 1'b0; in_tag = '0;
        dividend = 16'h00FF; divisor = 8'h03; out_ready = 1'b1;

        // Reset state, with a handshake attempt that must be ignored.
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", out_valid,       1'b0);
        chk("rst_busy",      busy,            1'b0);
        chk("rst_q",         quotient,        16'h0);
        chk("rst_r",         remainder,       8'h0);
        chk("rst_tag",       out_tag,         4'h0);
        chk("rst_dbz",       out_div_by_zero, 1'b0);
        reset_n = 1'b1; in_valid = 1'b0;
        chk("rst_in_ready",  in_ready,        1'b1);
        @(posedge clock);
        @(negedge clock);
        chk("rst_ignored", out_valid | busy, 1'b0);

        // Directed vectors.
        run_one("u1000_7",   1'b0, 16'h03E8, 8'h07, 4'h3, 16'h008E, 8'h06, 1'b0);
        run_one("s_m100_7",  1'b1, 16'hFF9C, 8'h07, 4'h5, 16'hFFF2, 8'hFE, 1'b0);
        run_one("s_min_m1",  1'b1, 16'h8000, 8'hFF, 4'h6, 16'h8000, 8'h00, 1'b0);
        run_one("u_dbz",     1'b0, 16'h1234, 8'h00, 4'h7, 16'hFFFF, 8'h34, 1'b1);
        run_one("s_dbz",     1'b1, 16'h1234, 8'h00, 4'h8, 16'hFFFF, 8'h34, 1'b1);
        run_one("s_dbz_neg", 1'b1, 16'hEDCC, 8'h00, 4'h9, 16'hFFFF, 8'hCC, 1'b1);
        run_one("s_100_m7",  1'b1, 16'h0064, 8'hF9, 4'hA, 16'hFFF2, 8'h02, 1'b0);
        run_one("u_max",     1'b0, 16'hFFFF, 8'hFF, 4'hB, 16'h0101, 8'h00, 1'b0);
        run_one("u_small",   1'b0, 16'h0005, 8'hC8, 4'hC, 16'h0000, 8'h05, 1'b0);
        run_one("s_256_m128",1'b1, 16'h0100, 8'h80, 4'hD, 16'hFFFE, 8'h00, 1'b0);
        run_one("u_8000_80", 1'b0, 16'h8000, 8'h80, 4'hE, 16'h0100, 8'h00, 1'b0);
        run_one("s_m100_m7", 1'b1, 16'hFF9C, 8'hF9, 4'hF, 16'h000E, 8'hFE, 1'b0);

        // 20 back-to-back operations with the sink always ready.
        sb.delete();
        fork
            begin
                for (int i = 0; i < 20; i++)
                    drive(rand_op(i));
                @(negedge clock);
                in_valid = 1'b0;
            end
            begin
                int wt;
                @(negedge clock);
                wt = 0;
                while (!out_valid && wt < 60) begin
                    @(posedge clock); wt++; @(negedge clock);
                end
                for (int j = 0; j < 20; j++) begin
                    chk("burst_valid", out_valid, 1'b1);
                    if (j < sb.size())
                        check_out("burst", sb[j]);
                    @(posedge clock);
                    @(negedge clock);
                end
                chk("burst_end", out_valid, 1'b0);
            end
        join

        // Output stall for 5 cycles with the pipe partly full.
        sb.delete();
        for (int i = 0; i < 6; i++)
            drive(rand_op(i + 3));
        @(negedge clock);
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 60) begin
            @(posedge clock); w++; @(negedge clock);
        end
        out_ready = 1'b0;
        in_valid = 1'b1; in_signed = 1'b0; dividend = 16'h0777; divisor = 8'h05; in_tag = 4'h0;
        for (int s = 0; s < 5; s++) begin
            @(posedge clock);
            @(negedge clock);
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            check_out("stall_hold", sb[0]);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                if (idx < 6)
                    check_out("stall_drain", sb[idx]);
                idx++;
            end
            @(posedge clock);
            @(negedge clock);
        end
        chk("stall_count", idx, 6);

        // Reset with 10 operations in flight.
        sb.delete();
        for (int i = 0; i < 10; i++)
            drive(rand_op(i));
        @(negedge clock);
        chk("flight_busy", busy, 1'b1);
        reset_n = 1'b0;
        in_valid = 1'b1; in_signed = 1'b0; dividend = 16'h0064; divisor = 8'h0A; in_tag = 4'h1;
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1; in_valid = 1'b0;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy",      busy,      1'b0);
        chk("mid_rst_in_ready",  in_ready,  1'b1);
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (out_valid)
                cnt++;
            @(posedge clock);
            @(negedge clock);
        end
        chk("mid_rst_stale", cnt, 0);
        chk("mid_rst_idle",  busy, 1'b0);

        run_one("post_rst", 1'b0, 16'h03E8, 8'h07, 4'h3, 16'h008E, 8'h06, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
